// File: rtl/capture_pkg.sv
// Shared types and defaults for the camera frame capture path.
// Holds the controller state type, default geometry and an address-width helper.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      CAPTURE,
      FROZEN
   } state_t;

   localparam int unsigned DEF_IMG_W  = 640;
   localparam int unsigned DEF_IMG_H  = 480;
   localparam int unsigned DEF_WIN_W  = 150;
   localparam int unsigned DEF_WIN_H  = 150;
   localparam int unsigned DEF_DATA_W = 16;

   // Smallest width w with 2**w >= depth.
   function automatic int unsigned addr_width(input int unsigned depth);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(depth)) w = i + 1;
      end
      return w;
   endfunction

   localparam int unsigned DEF_ADDR_W = addr_width(DEF_WIN_W * DEF_WIN_H);

endpackage

// File: rtl/frame_pos_counter.sv
// Tracks the (h, v) raster position of accepted pixels within a camera frame.
// Reports whether the current pixel lies in the stored window and whether it is the last of the frame.
module frame_pos_counter
   import capture_pkg::*;
#(
   parameter int unsigned IMG_W = DEF_IMG_W,
   parameter int unsigned IMG_H = DEF_IMG_H,
   parameter int unsigned WIN_W = DEF_WIN_W,
   parameter int unsigned WIN_H = DEF_WIN_H
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic step,
   output logic in_window,
   output logic last_pixel
);

   // One extra bit so a window as wide as the image still fits the compare constant.
   localparam int unsigned HW = $clog2(IMG_W + 1);
   localparam int unsigned VW = $clog2(IMG_H + 1);

   localparam logic [HW-1:0] H_LAST = HW'(IMG_W - 1);
   localparam logic [VW-1:0] V_LAST = VW'(IMG_H - 1);
   localparam logic [HW-1:0] H_WIN  = HW'(WIN_W);
   localparam logic [VW-1:0] V_WIN  = VW'(WIN_H);

   logic [HW-1:0] h;
   logic [VW-1:0] v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (clr) begin
         h <= '0;
         v <= '0;
      end else if (step) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   always_comb begin
      in_window  = (h < H_WIN) && (v < V_WIN);
      last_pixel = (h == H_LAST) && (v == V_LAST);
   end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Sequences camera pixels into the frame buffer write port, storing the top-left window.
// Freeze requests take effect only at frame boundaries so the buffer always holds a whole frame.
module frame_capture_ctrl
   import capture_pkg::*;
#(
   parameter int unsigned IMG_W  = DEF_IMG_W,
   parameter int unsigned IMG_H  = DEF_IMG_H,
   parameter int unsigned WIN_W  = DEF_WIN_W,
   parameter int unsigned WIN_H  = DEF_WIN_H,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              frame_start,
   input  logic              run,
   input  logic              err_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_done,
   output logic              frozen,
   output logic              busy,
   output logic              err_short,
   output logic              err_stray,
   output logic [7:0]        frame_cnt
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(WIN_W * WIN_H - 1);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] addr;
   logic              pos_clr;
   logic              accept;
   logic              short_evt;
   logic              stray_evt;
   logic              in_window;
   logic              last_pixel;
   logic              write;
   logic              eof;

   frame_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .WIN_W (WIN_W),
      .WIN_H (WIN_H)
   ) u_pos (
      .clk        (clk),
      .rst        (rst),
      .clr        (pos_clr),
      .step       (accept),
      .in_window  (in_window),
      .last_pixel (last_pixel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // frame_start always takes priority over a coincident pixel strobe.
   always_comb begin
      next_state = state;
      pos_clr    = 1'b0;
      accept     = 1'b0;
      short_evt  = 1'b0;
      stray_evt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (run) next_state = ARM;
         end
         ARM: begin
            if (frame_start) begin
               pos_clr    = 1'b1;
               next_state = CAPTURE;
            end else if (pix_valid) begin
               stray_evt = 1'b1;
            end
         end
         CAPTURE: begin
            if (frame_start) begin
               short_evt = 1'b1;
               pos_clr   = 1'b1;
            end else if (pix_valid) begin
               accept = 1'b1;
               if (last_pixel) next_state = run ? ARM : FROZEN;
            end
         end
         FROZEN: begin
            if (run) next_state = ARM;
         end
         default: next_state = IDLE;
      endcase
   end

   assign write  = accept & in_window;
   assign eof    = accept & last_pixel;
   assign busy   = (state == CAPTURE);
   assign frozen = (state == FROZEN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         addr       <= '0;
         frame_cnt  <= '0;
         err_short  <= 1'b0;
         err_stray  <= 1'b0;
      end else begin
         wr_en      <= write;
         frame_done <= eof;
         if (write) begin
            wr_addr <= addr;
            wr_data <= pix_data;
         end
         // Saturate rather than wrap so a stray extra pixel can never overwrite address 0.
         if (pos_clr)
            addr <= '0;
         else if (write && (addr != ADDR_MAX))
            addr <= addr + ADDR_W'(1);
         if (eof) frame_cnt <= frame_cnt + 8'd1;
         err_short <= short_evt | (err_short & ~err_clr);
         err_stray <= stray_evt | (err_stray & ~err_clr);
      end
   end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized bench for frame_capture_ctrl on a reduced 12x8 image with a 5x4 window.
// A raster-index reference model predicts every output each cycle; literal checks pin key points.
module tb_frame_capture_ctrl;

   localparam int unsigned IMG_W  = 12;
   localparam int unsigned IMG_H  = 8;
   localparam int unsigned WIN_W  = 5;
   localparam int unsigned WIN_H  = 4;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned NPIX   = IMG_W * IMG_H;
   localparam int unsigned NWIN   = WIN_W * WIN_H;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              pix_valid = 1'b0;
   logic [DATA_W-1:0] pix_data = '0;
   logic              frame_start = 1'b0;
   logic              run = 1'b0;
   logic              err_clr = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              frame_done;
   logic              frozen;
   logic              busy;
   logic              err_short;
   logic              err_stray;
   logic [7:0]        frame_cnt;

   frame_capture_ctrl #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .WIN_W  (WIN_W),
      .WIN_H  (WIN_H),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .frame_start (frame_start),
      .run         (run),
      .err_clr     (err_clr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .frozen      (frozen),
      .busy        (busy),
      .err_short   (err_short),
      .err_stray   (err_stray),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: mode plus raster index of the next pixel in the frame.
   typedef enum {M_IDLE, M_ARM, M_CAP, M_FROZEN} mode_t;
   mode_t             m_mode  = M_IDLE;
   int unsigned       m_pidx  = 0;
   logic              e_wr_en = 1'b0;
   logic [31:0]       e_addr  = '0;
   logic [DATA_W-1:0] e_data  = '0;
   logic              e_done  = 1'b0;
   logic              e_short = 1'b0;
   logic              e_stray = 1'b0;
   int unsigned       e_cnt   = 0;
   bit                ev_short;
   bit                ev_stray;
   int unsigned       mh;
   int unsigned       mv;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode  = M_IDLE;
         m_pidx  = 0;
         e_wr_en = 1'b0;
         e_addr  = '0;
         e_data  = '0;
         e_done  = 1'b0;
         e_short = 1'b0;
         e_stray = 1'b0;
         e_cnt   = 0;
      end else begin
         ev_short = 1'b0;
         ev_stray = 1'b0;
         e_wr_en  = 1'b0;
         e_done   = 1'b0;
         case (m_mode)
            M_IDLE:   if (run) m_mode = M_ARM;
            M_FROZEN: if (run) m_mode = M_ARM;
            M_ARM: begin
               if (frame_start) begin
                  m_mode = M_CAP;
                  m_pidx = 0;
               end else if (pix_valid) begin
                  ev_stray = 1'b1;
               end
            end
            M_CAP: begin
               if (frame_start) begin
                  ev_short = 1'b1;
                  m_pidx   = 0;
               end else if (pix_valid) begin
                  mh = m_pidx % IMG_W;
                  mv = m_pidx / IMG_W;
                  if (mh < WIN_W && mv < WIN_H) begin
                     e_wr_en = 1'b1;
                     e_addr  = mv * WIN_W + mh;
                     e_data  = pix_data;
                  end
                  if (m_pidx == NPIX - 1) begin
                     e_done = 1'b1;
                     e_cnt  = (e_cnt + 1) % 256;
                     m_mode = run ? M_ARM : M_FROZEN;
                     m_pidx = 0;
                  end else begin
                     m_pidx = m_pidx + 1;
                  end
               end
            end
            default: m_mode = M_IDLE;
         endcase
         e_short = ev_short || (e_short && !err_clr);
         e_stray = ev_stray || (e_stray && !err_clr);
      end
   end

   logic [ADDR_W-1:0] log_addr[$];
   logic [DATA_W-1:0] log_data[$];
   int unsigned       done_seen = 0;
   bit                cmp_on = 1'b0;

   always @(negedge clk) begin
      if (cmp_on) begin
         check("wr_en",      32'(wr_en),      32'(e_wr_en));
         check("wr_addr",    32'(wr_addr),    e_addr);
         check("wr_data",    32'(wr_data),    32'(e_data));
         check("frame_done", 32'(frame_done), 32'(e_done));
         check("busy",       32'(busy),       32'(m_mode == M_CAP));
         check("frozen",     32'(frozen),     32'(m_mode == M_FROZEN));
         check("err_short",  32'(err_short),  32'(e_short));
         check("err_stray",  32'(err_stray),  32'(e_stray));
         check("frame_cnt",  32'(frame_cnt),  e_cnt);
         if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
         end
         if (frame_done) done_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_pixels(input int unsigned n, input int unsigned gap_max,
                              input bit use_index, output logic [DATA_W-1:0] first);
      for (int unsigned i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_data  = use_index ? DATA_W'(i) : DATA_W'($urandom);
         if (i == 0) first = pix_data;
         tick();
         pix_valid = 1'b0;
         if (gap_max != 0) repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"},      32'(wr_en),      0);
      check({tag, "_wr_addr"},    32'(wr_addr),    0);
      check({tag, "_wr_data"},    32'(wr_data),    0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_frozen"},     32'(frozen),     0);
      check({tag, "_busy"},       32'(busy),       0);
      check({tag, "_err_short"},  32'(err_short),  0);
      check({tag, "_err_stray"},  32'(err_stray),  0);
      check({tag, "_frame_cnt"},  32'(frame_cnt),  0);
   endtask

   logic [DATA_W-1:0] first;

   initial begin
      #1 rst = 1'b1;
      cmp_on = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Frame 1: back-to-back pixels with data equal to the raster index.
      run = 1'b1;
      tick();
      log_addr.delete(); log_data.delete(); done_seen = 0;
      send_fs();
      send_pixels(NPIX, 0, 1'b1, first);
      repeat (3) tick();
      check("f1_writes", log_addr.size(), NWIN);
      if (log_addr.size() == NWIN) begin
         check("f1_first_addr", 32'(log_addr[0]), 0);
         check("f1_first_data", 32'(log_data[0]), 0);
         check("f1_rowend_addr", 32'(log_addr[4]), 4);
         check("f1_row1_addr", 32'(log_addr[5]), 5);
         check("f1_row1_data", 32'(log_data[5]), 12);
         check("f1_last_addr", 32'(log_addr[19]), 19);
         check("f1_last_data", 32'(log_data[19]), 40);
      end
      check("f1_done_pulses", done_seen, 1);
      check("f1_frame_cnt", 32'(frame_cnt), 1);

      // Frame 2: random data and gaps, freeze requested mid-frame.
      send_fs();
      send_pixels(40, 2, 1'b0, first);
      run = 1'b0;
      send_pixels(NPIX - 40, 2, 1'b0, first);
      repeat (2) tick();
      check("f2_frozen", 32'(frozen), 1);
      check("f2_frame_cnt", 32'(frame_cnt), 2);
      log_addr.delete();
      send_fs();
      send_pixels(NPIX, 0, 1'b0, first);
      tick();
      check("frozen_writes", log_addr.size(), 0);
      check("frozen_no_short", 32'(err_short), 0);
      check("frozen_no_stray", 32'(err_stray), 0);
      run = 1'b1;
      tick();
      check("unfrozen", 32'(frozen), 0);
      log_addr.delete();
      send_fs();
      send_pixels(NPIX, 1, 1'b0, first);
      repeat (2) tick();
      check("f3_writes", log_addr.size(), NWIN);

      // Short frame: restart after 50 pixels.
      done_seen = 0;
      send_fs();
      send_pixels(50, 1, 1'b0, first);
      log_addr.delete();
      send_fs();
      tick();
      check("short_flag", 32'(err_short), 1);
      check("short_no_done", done_seen, 0);
      send_pixels(NPIX, 0, 1'b0, first);
      tick();
      check("short_next_addr", 32'(log_addr[0]), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      check("short_cleared", 32'(err_short), 0);

      // Stray pixel in ARM, then a pixel coincident with frame_start.
      send_pixels(1, 0, 1'b0, first);
      tick();
      check("stray_flag", 32'(err_stray), 1);
      log_addr.delete(); log_data.delete();
      pix_valid = 1'b1; pix_data = 16'hBEEF; frame_start = 1'b1;
      tick();
      pix_valid = 1'b0; frame_start = 1'b0;
      send_pixels(NPIX, 0, 1'b0, first);
      tick();
      check("coinc_addr", 32'(log_addr[0]), 0);
      check("coinc_data", 32'(log_data[0]), 32'(first));
      check("coinc_writes", log_addr.size(), NWIN);
      check("f5_frame_cnt", 32'(frame_cnt), 5);

      // Asynchronous reset in the middle of a frame.
      send_fs();
      send_pixels(25, 0, 1'b0, first);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("midreset");
      run = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      log_addr.delete();
      send_fs();
      send_pixels(NPIX, 0, 1'b0, first);
      tick();
      check("postreset_writes", log_addr.size(), 0);
      run = 1'b1;
      tick();
      send_fs();
      send_pixels(NPIX, 0, 1'b0, first);
      tick();
      check("postreset_capture", log_addr.size(), NWIN);

      // 256 back-to-back frames: counter wraps back to where it started.
      done_seen = 0;
      for (int unsigned f = 0; f < 256; f++) begin
         send_fs();
         send_pixels(NPIX, 0, 1'b0, first);
         if (f == 254) begin
            tick();
            check("wrap_frame_cnt", 32'(frame_cnt), 0);
         end
      end
      repeat (2) tick();
      check("wrap_done_pulses", done_seen, 256);
      check("wrap_end_cnt", 32'(frame_cnt), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences camera-to-frame-buffer writes.
- Takes clk-synchronous pixel strobes and frame-start strobes, tracks the pixel position within the 640x480 stream, and writes only the top-left WIN_W x WIN_H window into buffer port A, using incremental addressing.
- Implements live/freeze control: a freeze request always lands on a clean frame boundary, so the buffer holds a complete frame.
- Sits between the camera capture logic and the Buffer write port.

Parameters:
- IMG_W, 640, pixels per camera line.
- IMG_H, 480, lines per camera frame.
- WIN_W, 150, stored window width.
- WIN_H, 150, stored window height.
- ADDR_W, 15, buffer address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H.
- DATA_W, 16, pixel width (RGB565).

Ports:
- clk, in, 1, system clock (clk_25 domain).
- rst, in, 1, asynchronous active-high reset.
- pix_valid, in, 1, one-cycle strobe: pix_data holds a complete pixel.
- pix_data, in, DATA_W, pixel value.
- frame_start, in, 1, one-cycle strobe at the start of each camera frame (vsync edge).
- run, in, 1, level: 1 = live capture, 0 = freeze request.
- err_clr, in, 1, one-cycle clear for sticky error flags.
- wr_en, out, 1, buffer write enable (one cycle per stored pixel).
- wr_addr, out, ADDR_W, buffer write address.
- wr_data, out, DATA_W, buffer write data.
- frame_done, out, 1, one-cycle pulse when the last pixel of a full frame is accepted.
- frozen, out, 1, high while in FROZEN.
- busy, out, 1, high while in CAPTURE.
- err_short, out, 1, sticky: frame_start arrived before a full frame completed.
- err_stray, out, 1, sticky: pix_valid arrived while in ARM (before frame_start).
- frame_cnt, out, 8, count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (async, immediate): state = IDLE; h = 0, v = 0; wr_addr = 0; wr_data = 0; frame_cnt = 0. All 1-bit outputs are 0.
- IDLE: go to ARM when run = 1.
- ARM:
  - frame_start: h = 0, v = 0, address = 0; go to CAPTURE.
  - pix_valid without frame_start: pixel ignored, err_stray set.
- CAPTURE, on pix_valid:
  - If h < WIN_W and v < WIN_H: next cycle wr_en = 1, wr_addr = current address, wr_data = pixel. The address then increments by 1. Write latency is exactly 1 cycle; no multiplier.
  - Otherwise: wr_en stays 0.
  - h increments; at h = IMG_W-1 it wraps to 0 and v increments.
- CAPTURE, end of frame (pixel at h = IMG_W-1, v = IMG_H-1):
  - frame_done pulses in the same cycle as that pixel's wr_en (window-dependent; frame_done is 1 cycle after the pixel).
  - frame_cnt increments.
  - Next state is ARM if run = 1, else FROZEN.
- CAPTURE, frame_start before end of frame:
  - err_short set, no frame_done, counters and address cleared; stay in CAPTURE.
- pix_valid and frame_start in the same cycle: frame_start wins and the pixel is discarded (it does not count as (0,0)).
- run deasserted mid-frame: capture continues to end of frame, then FROZEN. Buffer contents are never partial.
- FROZEN: wr_en never asserted; pix_valid and frame_start are ignored with no error flags. run = 1 -> ARM.
- Address range: the maximum wr_addr is WIN_W*WIN_H-1 (22499). The address counter saturates there and never wraps within a frame.
- err_clr: clears both sticky flags. If an error event occurs in the same cycle, the flag stays set (set wins).
- pix_valid spacing: may arrive on back-to-back cycles. The block accepts one pixel per clk.

Decomposition:
- Shared package capture_pkg:
  - state enum {IDLE, ARM, CAPTURE, FROZEN};
  - default window and image constants;
  - address-width function clog2(WIN_W*WIN_H).
- Sub-module frame_pos_counter:
  - h/v counters with wrap;
  - in_window flag;
  - last_pixel flag;
  - synchronous clear.
- The FSM, address counter and error flags stay in the top level.

Test Plan:
- Reset, run = 1, frame_start, then 307200 back-to-back pix_valid with data = index:
  - 22500 writes;
  - first write addr 0, data 0;
  - write at (h = 149, v = 0) has addr 149;
  - pixel (0,1) (data 640) goes to addr 150;
  - last write addr 22499, data 149*640+149;
  - one frame_done pulse; frame_cnt = 1.
- Drop run at pixel 1000 of frame 2:
  - frame 2 completes, then FROZEN, frozen = 1;
  - a following frame_start plus pixels produce zero wr_en;
  - run = 1 -> ARM, then the next frame is captured.
- frame_start after 5000 pixels:
  - err_short = 1, no frame_done;
  - the next write is at addr 0;
  - err_clr -> err_short = 0.
- pix_valid in ARM, and pix_valid coinciding with frame_start:
  - err_stray = 1 for the ARM pixel;
  - the coincident pixel is not written;
  - the next pixel is written to addr 0.
- Assert rst mid-CAPTURE at pixel 300:
  - all outputs are 0 immediately;
  - the block returns to IDLE and needs run plus frame_start before writing again.
- Run 256 full frames: frame_cnt wraps to 0 and frame_done pulses 256 times.
